// File: rtl/adder8_seq_ctrl.sv
// Byte-serial multi-byte adder sequencer driving one shared 8-bit adder slice.
// Operands are latched at start; the carry is registered between bytes, LSB first.
module adder8_seq_ctrl #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [8*NBYTES-1:0] a,
  input  logic [8*NBYTES-1:0] b,
  input  logic                ci,
  output logic [7:0]          add_a,
  output logic [7:0]          add_b,
  output logic                add_ci,
  input  logic [7:0]          add_s,
  input  logic                add_co,
  output logic                busy,
  output logic                done,
  output logic [8*NBYTES-1:0] sum,
  output logic                co
);

  localparam int unsigned W  = 8 * NBYTES;
  localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [IW-1:0]              idx_q, idx_d;
  logic                       carry_q, carry_d;
  logic [NBYTES-1:0][7:0]     opa_q, opa_d;
  logic [NBYTES-1:0][7:0]     opb_q, opb_d;
  logic [NBYTES-1:0][7:0]     part_q, part_d;
  logic [W-1:0]               sum_q, sum_d;
  logic                       co_q, co_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;

  logic                       launch;
  logic [NBYTES-1:0][7:0]     part_nxt;

  // A new add may begin from IDLE or directly out of DONE.
  assign launch = start && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    part_d   = part_q;
    sum_d    = sum_q;
    co_d     = co_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    part_nxt = part_q;

    case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      RUN: begin
        part_nxt[idx_q] = add_s;
        part_d          = part_nxt;
        carry_d         = add_co;
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          sum_d   = part_nxt;
          co_d    = add_co;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (launch) begin
      opa_d   = a;
      opb_d   = b;
      carry_d = ci;
      idx_d   = '0;
      busy_d  = 1'b1;
      state_d = RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      part_q  <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      part_q  <= part_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Adder slice inputs are decoded from state so they read zero outside RUN.
  always_comb begin
    add_a  = 8'h00;
    add_b  = 8'h00;
    add_ci = 1'b0;
    if (state_q == RUN) begin
      add_a  = opa_q[idx_q];
      add_b  = opb_q[idx_q];
      add_ci = carry_q;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign co   = co_q;

endmodule

// File: tb/tb_adder8_seq_ctrl.sv
// Scoreboard bench for adder8_seq_ctrl: 4-byte and 1-byte instances, each with
// a behavioural adder8 slice attached and a monitor checking every done pulse.
module tb_adder8_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 4-byte instance
  logic        start4 = 1'b0;
  logic [31:0] a4 = '0, b4 = '0;
  logic        ci4 = 1'b0;
  logic [7:0]  add_a4, add_b4, add_s4;
  logic        add_ci4, add_co4;
  logic        busy4, done4, co4;
  logic [31:0] sum4;

  assign {add_co4, add_s4} = 9'(add_a4) + 9'(add_b4) + 9'(add_ci4);

  adder8_seq_ctrl #(.NBYTES(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .ci(ci4),
    .add_a(add_a4), .add_b(add_b4), .add_ci(add_ci4),
    .add_s(add_s4), .add_co(add_co4),
    .busy(busy4), .done(done4), .sum(sum4), .co(co4)
  );

  // 1-byte instance
  logic        start1 = 1'b0;
  logic [7:0]  a1 = '0, b1 = '0;
  logic        ci1 = 1'b0;
  logic [7:0]  add_a1, add_b1, add_s1;
  logic        add_ci1, add_co1;
  logic        busy1, done1, co1;
  logic [7:0]  sum1;

  assign {add_co1, add_s1} = 9'(add_a1) + 9'(add_b1) + 9'(add_ci1);

  adder8_seq_ctrl #(.NBYTES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .ci(ci1),
    .add_a(add_a1), .add_b(add_b1), .add_ci(add_ci1),
    .add_s(add_s1), .add_co(add_co1),
    .busy(busy1), .done(done1), .sum(sum1), .co(co1)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] s;
    logic        c;
    int          cyc;
  } exp_t;

  exp_t q4[$];
  exp_t q1[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s", name);
  endtask

  // Monitor for the 4-byte instance
  logic [31:0] last_sum4 = '0;
  logic        last_co4 = 1'b0;
  int          busy_run4 = 0;

  always @(negedge clk) begin : mon4
    exp_t e;
    if (rst) begin
      busy_run4 = 0;
      last_sum4 = '0;
      last_co4  = 1'b0;
    end else begin
      if (busy4) begin
        busy_run4++;
        chk("hold4", 64'({sum4, co4}), 64'({last_sum4, last_co4}));
      end
      if (done4) begin
        if (q4.size() == 0) fail("unexpected_done4");
        else begin
          e = q4.pop_front();
          chk("sum4", 64'(sum4), 64'(e.s));
          chk("co4", 64'(co4), 64'(e.c));
          chk("latency4", 64'(cyc), 64'(e.cyc));
          chk("busy_len4", 64'(busy_run4), 64'd4);
          last_sum4 = e.s;
          last_co4  = e.c;
        end
        busy_run4 = 0;
      end
    end
  end

  // Monitor for the 1-byte instance
  int busy_run1 = 0;

  always @(negedge clk) begin : mon1
    exp_t e;
    if (rst) begin
      busy_run1 = 0;
    end else begin
      if (busy1) busy_run1++;
      if (done1) begin
        if (q1.size() == 0) fail("unexpected_done1");
        else begin
          e = q1.pop_front();
          chk("sum1", 64'(sum1), 64'(e.s));
          chk("co1", 64'(co1), 64'(e.c));
          chk("latency1", 64'(cyc), 64'(e.cyc));
          chk("busy_len1", 64'(busy_run1), 64'd1);
        end
        busy_run1 = 0;
      end
    end
  end

  // Call just after a negedge; start is sampled at the next posedge.
  task automatic issue4(input logic [31:0] a, input logic [31:0] b, input logic c,
                        input logic [31:0] es, input logic ec);
    exp_t e;
    a4 = a; b4 = b; ci4 = c; start4 = 1'b1;
    e.s = es; e.c = ec; e.cyc = cyc + 5;
    q4.push_back(e);
    @(negedge clk);
    start4 = 1'b0;
    a4 = $urandom; b4 = $urandom; ci4 = 1'($urandom);
  endtask

  task automatic issue1(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [7:0] es, input logic ec);
    exp_t e;
    a1 = a; b1 = b; ci1 = c; start1 = 1'b1;
    e.s = 32'(es); e.c = ec; e.cyc = cyc + 2;
    q1.push_back(e);
    @(negedge clk);
    start1 = 1'b0;
    a1 = 8'($urandom); b1 = 8'($urandom); ci1 = 1'($urandom);
  endtask

  task automatic wait_done4();
    int n = 0;
    while (!done4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!done4) fail("timeout_done4");
  endtask

  task automatic wait_done1();
    int n = 0;
    while (!done1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!done1) fail("timeout_done1");
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    // Reset holds everything at zero even with start asserted.
    start4 = 1'b1; a4 = 32'h1234_5678; b4 = 32'h1; ci4 = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy4), 64'd0);
    chk("rst_done", 64'(done4), 64'd0);
    chk("rst_sum", 64'(sum4), 64'd0);
    chk("rst_co", 64'(co4), 64'd0);
    chk("rst_add_drive", 64'({add_a4, add_b4, add_ci4}), 64'd0);
    chk("rst_sum1", 64'({sum1, co1, busy1}), 64'd0);
    start4 = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // 500 + 1000 + 1; first RUN cycle drives byte 0 of the latched operands
    issue4(32'd500, 32'd1000, 1'b1, 32'd1501, 1'b0);
    chk("run_add_a", 64'(add_a4), 64'h0F4);
    chk("run_add_b", 64'(add_b4), 64'h0E8);
    chk("run_add_ci", 64'(add_ci4), 64'd1);
    wait_done4();
    chk("idle_add_drive", 64'({add_a4, add_b4, add_ci4}), 64'd0);
    @(negedge clk);

    // Full carry ripple
    issue4(32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 1'b1);
    wait_done4();
    @(negedge clk);

    // All-ones with carry-in, then back-to-back with start high during DONE
    issue4(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1);
    wait_done4();
    issue4(32'd320, 32'd400, 1'b0, 32'd720, 1'b0);
    wait_done4();
    @(negedge clk);

    // start during RUN is ignored
    issue4(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0);
    @(negedge clk);
    a4 = 32'h1; b4 = 32'h1; ci4 = 1'b1; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    wait_done4();
    repeat (8) @(negedge clk);

    // Carry across the byte-1/byte-2 boundary
    issue4(32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0);
    wait_done4();
    @(negedge clk);

    // Asynchronous reset in the middle of RUN
    a4 = 32'hAAAA_AAAA; b4 = 32'h5555_5555; ci4 = 1'b1; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 64'(busy4), 64'd0);
    chk("abort_done", 64'(done4), 64'd0);
    chk("abort_sum", 64'(sum4), 64'd0);
    chk("abort_co", 64'(co4), 64'd0);
    chk("abort_add_drive", 64'({add_a4, add_b4, add_ci4}), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue4(32'h8000_0000, 32'h8000_0000, 1'b1, 32'h1, 1'b1);
    wait_done4();
    @(negedge clk);

    // Single-byte instance
    issue1(8'hF0, 8'h20, 1'b0, 8'h10, 1'b1);
    wait_done1();
    @(negedge clk);
    issue1(8'h7F, 8'h00, 1'b1, 8'h80, 1'b0);
    wait_done1();

    repeat (6) @(negedge clk);
    chk("q4_drained", 64'(q4.size()), 64'd0);
    chk("q1_drained", 64'(q1.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
